sha256_scheduler: RTL and testbench

- Shares one sha256 core among N_REQ requesters.
- Round-robin arbitration over submitted ShaContext jobs; one job in flight at a time.
- Forwards the granted context to the core, waits for the hash, and routes it into the owning requester's result slot.
- Sits between host/job sources and the sha256 top-level ctx/hash ports; watchdog aborts hung jobs.

---
 rtl/sha256_scheduler.sv | 231 +++++++++++++++++++++++
 tb/tb_sha256_scheduler.sv | 382 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_scheduler.sv
// -----------------------------------------------------------------------------
// sha256_scheduler
//
// Shares a single sha256 core among N_REQ requesters. Jobs are granted
// round-robin, one at a time. The granted context goes to the core, and the
// returned digest is stored in the owning requester's result slot. A
// watchdog aborts a job whose hash never comes back.
//
// Optional build macro: SHA_SCHED_STATS_EN adds per-requester success
// counters (jobs_done) and a busy-cycle counter (busy_cycles).
//
// Handshake semantics (all valid/ready pairs in this block):
//   A transfer happens on a rising clk edge where valid && ready are both 1.
//   Once raised, valid holds and its payload stays stable until that edge.
//   core_hash_vld is the exception: it is a single-cycle strobe with no ready.
//
// Ports:
//   clk, rst          clock and asynchronous active-low reset
//   req_vld/req_rdy   per-requester job handshake (req_rdy one-hot or zero)
//   req_ctx           per-requester job context
//   res_vld/res_rdy   per-requester result slot handshake
//   res_err           slot holds an aborted job (qualified by res_vld)
//   res_hash          per-slot digest, zero for aborted jobs
//   core_ctx_vld/rdy  context handshake towards the sha256 core
//   core_ctx          context driven to the core
//   core_hash_vld     digest strobe from the core
//   core_hash         digest from the core
//   busy              scheduler is not idle
//   err_timeout       sticky watchdog-abort flag
//   err_spurious      sticky flag for a digest strobe outside WAIT
//   err_clr           clears both sticky flags (and the stats counters)
//   jobs_done         (stats build) successful results per requester
//   busy_cycles       (stats build) cycles spent with busy=1
//   dbg_state         current FSM state: 0=IDLE 1=ISSUE 2=WAIT
// -----------------------------------------------------------------------------

package sha256_pkg;
  // Chaining value plus one message block.
  typedef struct packed {
    logic [255:0] h_in;
    logic [511:0] block;
  } ShaContext;
endpackage

module sha256_scheduler #(
  parameter int N_REQ          = 4,
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int CNT_W          = 16
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [N_REQ-1:0]                   req_vld,
  output logic [N_REQ-1:0]                   req_rdy,
  input  sha256_pkg::ShaContext [N_REQ-1:0]  req_ctx,
  output logic [N_REQ-1:0]                   res_vld,
  input  logic [N_REQ-1:0]                   res_rdy,
  output logic [N_REQ-1:0]                   res_err,
  output logic [N_REQ-1:0][255:0]            res_hash,
  output logic                               core_ctx_vld,
  input  logic                               core_ctx_rdy,
  output sha256_pkg::ShaContext              core_ctx,
  input  logic                               core_hash_vld,
  input  logic [255:0]                       core_hash,
  output logic                               busy,
  output logic                               err_timeout,
  output logic                               err_spurious,
  input  logic                               err_clr,
`ifdef SHA_SCHED_STATS_EN
  output logic [N_REQ-1:0][CNT_W-1:0]        jobs_done,
  output logic [CNT_W-1:0]                   busy_cycles,
`endif
  output logic [1:0]                         dbg_state
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  // A TIMEOUT_CYCLES of zero switches the watchdog off entirely.
  localparam logic             WD_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] owner;
  logic [CNT_W-1:0] wdog;

  logic [N_REQ-1:0] eligible;
  logic             grant_any;
  logic [IDX_W-1:0] grant_idx;
  logic [IDX_W:0]   scan_sum;
  logic [IDX_W-1:0] next_ptr;
  logic             wd_expire;
  logic             hash_hit;
  logic             timeout_hit;
  logic             spurious_hit;

  // ---------------------------------------------------------------------------
  // Round-robin search starting at rr_ptr. A requester whose slot still holds
  // an unread result is skipped, so its slot can never be overwritten.
  // ---------------------------------------------------------------------------
  always_comb begin
    eligible  = req_vld & ~res_vld;
    grant_any = 1'b0;
    grant_idx = '0;
    scan_sum  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      scan_sum = {1'b0, rr_ptr} + (IDX_W+1)'(k);
      if (scan_sum >= (IDX_W+1)'(N_REQ)) begin
        scan_sum = scan_sum - (IDX_W+1)'(N_REQ);
      end
      if (!grant_any && eligible[scan_sum[IDX_W-1:0]]) begin
        grant_any = 1'b1;
        grant_idx = scan_sum[IDX_W-1:0];
      end
    end
  end

  // Accept is only offered while idle; the job is captured on that edge.
  always_comb begin
    req_rdy = '0;
    if (state == S_IDLE && grant_any) begin
      req_rdy[grant_idx] = 1'b1;
    end
  end

  assign next_ptr     = (owner == IDX_W'(N_REQ - 1)) ? '0 : owner + 1'b1;
  assign wd_expire    = WD_EN && (wdog == WD_LAST);
  assign hash_hit     = (state == S_WAIT) && core_hash_vld;
  // A digest arriving on the expiry cycle wins over the abort.
  assign timeout_hit  = (state == S_WAIT) && !core_hash_vld && wd_expire;
  assign spurious_hit = (state != S_WAIT) && core_hash_vld;

  assign busy      = (state != S_IDLE);
  assign dbg_state = state;

  // ---------------------------------------------------------------------------
  // Scheduler FSM, result slots and sticky error flags.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= S_IDLE;
      rr_ptr       <= '0;
      owner        <= '0;
      wdog         <= '0;
      core_ctx_vld <= 1'b0;
      core_ctx     <= '0;
      res_vld      <= '0;
      res_err      <= '0;
      res_hash     <= '0;
      err_timeout  <= 1'b0;
      err_spurious <= 1'b0;
    end else begin
      // Consumed slots empty first; a slot being filled below belongs to an
      // owner that was ineligible while full, so the two never collide.
      res_vld <= res_vld & ~res_rdy;

      // Set has priority over clear.
      err_timeout  <= timeout_hit  | (err_timeout  & ~err_clr);
      err_spurious <= spurious_hit | (err_spurious & ~err_clr);

      case (state)
        S_IDLE: begin
          if (grant_any) begin
            core_ctx     <= req_ctx[grant_idx];
            owner        <= grant_idx;
            core_ctx_vld <= 1'b1;
            state        <= S_ISSUE;
          end
        end

        S_ISSUE: begin
          if (core_ctx_rdy) begin
            core_ctx_vld <= 1'b0;
            wdog         <= '0;
            state        <= S_WAIT;
          end
        end

        S_WAIT: begin
          if (hash_hit) begin
            res_hash[owner] <= core_hash;
            res_vld[owner]  <= 1'b1;
            res_err[owner]  <= 1'b0;
            rr_ptr          <= next_ptr;
            state           <= S_IDLE;
          end else if (timeout_hit) begin
            res_hash[owner] <= '0;
            res_vld[owner]  <= 1'b1;
            res_err[owner]  <= 1'b1;
            rr_ptr          <= next_ptr;
            state           <= S_IDLE;
          end else begin
            wdog <= wdog + 1'b1;
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef SHA_SCHED_STATS_EN
  // ---------------------------------------------------------------------------
  // Saturating statistics; err_clr restarts them.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      jobs_done   <= '0;
      busy_cycles <= '0;
    end else if (err_clr) begin
      jobs_done   <= '0;
      busy_cycles <= '0;
    end else begin
      if (busy && (busy_cycles != '1)) begin
        busy_cycles <= busy_cycles + 1'b1;
      end
      if (hash_hit && (jobs_done[owner] != '1)) begin
        jobs_done[owner] <= jobs_done[owner] + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_sha256_scheduler.sv
// -----------------------------------------------------------------------------
// tb_sha256_scheduler
//
// Drives sha256_scheduler with N_REQ=4 and a short watchdog, playing the role
// of both the requesters and the sha256 core. Expected grants come from a
// small round-robin model (slot occupancy + pointer) and from a hand-built
// arbitration table; expected results travel through exp_q.
// -----------------------------------------------------------------------------

module tb_sha256_scheduler;
  import sha256_pkg::*;

  localparam int N     = 4;
  localparam int T_OUT = 12;
  localparam int CW    = 16;

  // ---------------------------------------------------------------------------
  // Clock / reset and DUT
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst;
  logic [N-1:0]         req_vld;
  logic [N-1:0]         req_rdy;
  ShaContext [N-1:0]    req_ctx;
  logic [N-1:0]         res_vld;
  logic [N-1:0]         res_rdy;
  logic [N-1:0]         res_err;
  logic [N-1:0][255:0]  res_hash;
  logic                 core_ctx_vld;
  logic                 core_ctx_rdy;
  ShaContext            core_ctx;
  logic                 core_hash_vld;
  logic [255:0]         core_hash;
  logic                 busy;
  logic                 err_timeout;
  logic                 err_spurious;
  logic                 err_clr;
  logic [1:0]           dbg_state;
`ifdef SHA_SCHED_STATS_EN
  logic [N-1:0][CW-1:0] jobs_done;
  logic [CW-1:0]        busy_cycles;
`endif

  sha256_scheduler #(
    .N_REQ         (N),
    .TIMEOUT_CYCLES(T_OUT),
    .CNT_W         (CW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_vld      (req_vld),
    .req_rdy      (req_rdy),
    .req_ctx      (req_ctx),
    .res_vld      (res_vld),
    .res_rdy      (res_rdy),
    .res_err      (res_err),
    .res_hash     (res_hash),
    .core_ctx_vld (core_ctx_vld),
    .core_ctx_rdy (core_ctx_rdy),
    .core_ctx     (core_ctx),
    .core_hash_vld(core_hash_vld),
    .core_hash    (core_hash),
    .busy         (busy),
    .err_timeout  (err_timeout),
    .err_spurious (err_spurious),
    .err_clr      (err_clr),
`ifdef SHA_SCHED_STATS_EN
    .jobs_done    (jobs_done),
    .busy_cycles  (busy_cycles),
`endif
    .dbg_state    (dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard and reference model
  // ---------------------------------------------------------------------------
  int total = 0;
  int bad   = 0;
  logic [255:0] exp_q[$];
  logic [N-1:0] m_vld;   // model: which result slots are full
  int           m_rr;    // model: round-robin start index

  typedef struct {
    logic [N-1:0] req;
    int           grant;
  } arb_vec_t;
  arb_vec_t tbl[20];

  task automatic check(input string name, input logic [767:0] act, input logic [767:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int exp_grant(input logic [N-1:0] mask);
    for (int k = 0; k < N; k++) begin
      int i;
      i = (m_rr + k) % N;
      if (mask[i] && !m_vld[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] onehot(input int g);
    logic [N-1:0] v;
    v = '0;
    if (g >= 0) v[g] = 1'b1;
    return v;
  endfunction

  function automatic ShaContext rand_ctx();
    logic [767:0] v;
    for (int w = 0; w < 24; w++) v[w*32 +: 32] = $urandom();
    return ShaContext'(v);
  endfunction

  function automatic logic [255:0] rand_hash();
    logic [255:0] v;
    for (int w = 0; w < 8; w++) v[w*32 +: 32] = $urandom();
    return v;
  endfunction

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  // One clock: slot occupancy is compared before the edge, then the model
  // empties the slots the bench consumed on that edge.
  task automatic step();
    logic [N-1:0] clr;
    check("res_vld_model", res_vld, m_vld);
    clr = m_vld & res_rdy;
    @(posedge clk);
    #1;
    m_vld = m_vld & ~clr;
  endtask

  task automatic do_reset();
    rst           = 1'b0;
    req_vld       = '0;
    res_rdy       = '1;
    core_ctx_rdy  = 1'b0;
    core_hash_vld = 1'b0;
    core_hash     = '0;
    err_clr       = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst   = 1'b1;
    m_vld = '0;
    m_rr  = 0;
    exp_q.delete();
    @(posedge clk);
    #1;
  endtask

  // Runs one job through the scheduler acting as the core.
  //   rdy_dly : ISSUE cycles before the core accepts the context
  //   hash_dly: WAIT cycles before the digest strobe; -1 never sends one
  //             (watchdog abort), -2 returns once WAIT is entered
  task automatic run_job(input logic [N-1:0] mask, input logic keep_req,
                         input int rdy_dly, input int hash_dly, output int g);
    int           eg;
    int           n_idle;
    ShaContext    c_exp;
    logic [255:0] h;
    logic [255:0] e;
    g  = -1;
    eg = -1;
    for (int i = 0; i < N; i++) req_ctx[i] = rand_ctx();
    req_vld = mask;
    #1;
    for (int t = 0; t < 20; t++) begin
      eg = exp_grant(mask);
      check("req_rdy_grant", req_rdy, onehot(eg));
      if (eg >= 0) break;
      step();
    end
    if (eg < 0) begin
      total++;
      bad++;
      $display("FAIL grant_wait: got no eligible requester within 20 cycles, required a grant");
      req_vld = '0;
      return;
    end
    g     = eg;
    c_exp = req_ctx[g];
    step();
    if (!keep_req) req_vld = '0;
    for (int t = 0; t <= rdy_dly; t++) begin
      check("issue_ctx_vld", core_ctx_vld, 1'b1);
      check("issue_ctx", core_ctx, c_exp);
      check("issue_req_rdy", req_rdy, '0);
      check("issue_busy", busy, 1'b1);
      if (t == rdy_dly) core_ctx_rdy = 1'b1;
      step();
    end
    core_ctx_rdy = 1'b0;
    check("wait_ctx_vld", core_ctx_vld, 1'b0);
    if (hash_dly == -2) return;
    h = rand_hash();
    exp_q.push_back((hash_dly == -1) ? 256'd0 : h);
    n_idle = (hash_dly == -1) ? T_OUT - 1 : hash_dly;
    for (int t = 0; t < n_idle; t++) begin
      check("wait_no_result", res_vld[g], 1'b0);
      check("wait_busy", busy, 1'b1);
      step();
    end
    if (hash_dly >= 0) begin
      core_hash_vld = 1'b1;
      core_hash     = h;
    end
    step();
    core_hash_vld = 1'b0;
    m_vld[g] = 1'b1;
    m_rr     = (g + 1) % N;
    e = exp_q.pop_front();
    check("res_vld", res_vld[g], 1'b1);
    check("res_err", res_err[g], (hash_dly == -1));
    check("res_hash", res_hash[g], e);
    check("idle_after_result", busy, 1'b0);
    if (hash_dly == -1) check("err_timeout_set", err_timeout, 1'b1);
  endtask

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin
    int g;
    logic [N-1:0] mask;
    logic [N-1:0] rdy;
    int hd;

    tbl[0]  = '{4'b1111, 0};  tbl[1]  = '{4'b1111, 1};
    tbl[2]  = '{4'b1111, 2};  tbl[3]  = '{4'b1111, 3};
    tbl[4]  = '{4'b1111, 0};  tbl[5]  = '{4'b1111, 1};
    tbl[6]  = '{4'b1111, 2};  tbl[7]  = '{4'b1111, 3};
    tbl[8]  = '{4'b0101, 0};  tbl[9]  = '{4'b0101, 2};
    tbl[10] = '{4'b0101, 0};  tbl[11] = '{4'b1000, 3};
    tbl[12] = '{4'b0110, 1};  tbl[13] = '{4'b0011, 0};
    tbl[14] = '{4'b1001, 3};  tbl[15] = '{4'b1111, 0};
    tbl[16] = '{4'b0010, 1};  tbl[17] = '{4'b1100, 2};
    tbl[18] = '{4'b1100, 3};  tbl[19] = '{4'b1100, 2};

    for (int i = 0; i < N; i++) req_ctx[i] = '0;

    // Reset values, sampled while reset is held.
    rst = 1'b0;
    req_vld = '0; res_rdy = '1; core_ctx_rdy = 1'b0;
    core_hash_vld = 1'b0; core_hash = '0; err_clr = 1'b0;
    #2;
    check("rst_busy", busy, 1'b0);
    check("rst_state", dbg_state, 2'd0);
    check("rst_res_vld", res_vld, '0);
    check("rst_res_err", res_err, '0);
    check("rst_res_hash", |res_hash, 1'b0);
    check("rst_core_ctx_vld", core_ctx_vld, 1'b0);
    check("rst_core_ctx", core_ctx, '0);
    check("rst_err_timeout", err_timeout, 1'b0);
    check("rst_err_spurious", err_spurious, 1'b0);
    do_reset();

    // Single job on requester 2 with a slow core.
    res_rdy = 4'b1011;
    run_job(4'b0100, 1'b0, 3, 9, g);
    check("single_grant", g, 2);
    step();
    check("single_res_held", res_vld[2], 1'b1);
    res_rdy = '1;
    step();
    step();

    // Table: fairness followed by mixed request patterns.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      run_job(tbl[i].req, (i < 8), $urandom_range(0, 3), $urandom_range(0, 5), g);
      check("tbl_grant", g, tbl[i].grant);
    end
    req_vld = '0;
    step();

    // Full-slot blocking on requester 1.
    do_reset();
    res_rdy = 4'b1101;
    run_job(4'b0010, 1'b0, 0, 1, g);
    check("block_first", g, 1);
    req_vld = 4'b0010;
    for (int t = 0; t < 4; t++) begin
      #1;
      check("block_no_grant", req_rdy, '0);
      check("block_idle", busy, 1'b0);
      step();
    end
    run_job(4'b0011, 1'b1, 1, 2, g);
    check("block_only_0_a", g, 0);
    run_job(4'b0011, 1'b1, 0, 0, g);
    check("block_only_0_b", g, 0);
    res_rdy = '1;
    run_job(4'b0011, 1'b0, 0, 3, g);
    check("block_release_1", g, 1);
    step();

    // Watchdog abort, then err_clr.
    do_reset();
    res_rdy = 4'b0000;
    run_job(4'b0001, 1'b0, 2, -1, g);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check("timeout_cleared", err_timeout, 1'b0);
    check("timeout_slot_kept", res_err[0], 1'b1);
    res_rdy = '1;
    step();

    // Digest on the expiry cycle: the hash wins.
    run_job(4'b1000, 1'b0, 0, T_OUT - 1, g);
    check("coincide_no_err", err_timeout, 1'b0);
    step();

    // Spurious digest in IDLE, clear, and set-beats-clear.
    core_hash_vld = 1'b1;
    core_hash     = rand_hash();
    step();
    core_hash_vld = 1'b0;
    check("spurious_set", err_spurious, 1'b1);
    check("spurious_no_slot", res_vld, '0);
    err_clr = 1'b1;
    step();
    check("spurious_clr", err_spurious, 1'b0);
    core_hash_vld = 1'b1;
    step();
    core_hash_vld = 1'b0;
    check("spurious_set_wins", err_spurious, 1'b1);
    step();
    err_clr = 1'b0;
    check("spurious_clr2", err_spurious, 1'b0);

    // Reset in the middle of WAIT.
    run_job(4'b0100, 1'b0, 1, -2, g);
    step();
    #2;
    rst = 1'b0;
    #1;
    check("midrst_busy", busy, 1'b0);
    check("midrst_state", dbg_state, 2'd0);
    check("midrst_ctx_vld", core_ctx_vld, 1'b0);
    check("midrst_ctx", core_ctx, '0);
    check("midrst_res_vld", res_vld, '0);
    @(negedge clk);
    rst   = 1'b1;
    m_vld = '0;
    m_rr  = 0;
    exp_q.delete();
    @(posedge clk);
    #1;
    for (int t = 0; t < 15; t++) step();
    check("midrst_no_result", res_vld, '0);
    run_job(4'b0100, 1'b0, 0, 2, g);
    check("midrst_new_job", g, 2);
    step();

    // Randomized traffic against the model.
    for (int j = 0; j < 60; j++) begin
      mask = N'($urandom_range(1, (1 << N) - 1));
      rdy  = N'($urandom_range(0, (1 << N) - 1));
      if ((mask & ~(m_vld & ~rdy)) == '0) rdy = '1;
      res_rdy = rdy;
      hd = ($urandom_range(0, 7) == 0) ? -1 : $urandom_range(0, T_OUT - 1);
      run_job(mask, 1'($urandom_range(0, 1)), $urandom_range(0, 4), hd, g);
    end
    req_vld = '0;
    res_rdy = '1;
    step();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
